// File: rtl/led_pwm_fader_pkg.sv
// Shared types and helpers for the LED PWM fader.
// The square-law duty curve is used when LED_FADE_GAMMA_EN is defined.
package led_fade_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RISING  = 2'd1,
        ON      = 2'd2,
        FALLING = 2'd3
    } fade_state_e;

    localparam int unsigned PWM_BITS_DEF = 8;

    function automatic int unsigned max_level(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    localparam int unsigned MAX = max_level(PWM_BITS_DEF);

    // Square-law brightness curve; full scale is pinned so "on" stays constant high.
    function automatic logic [31:0] gamma(input logic [15:0] level, input int unsigned bits);
        logic [31:0] sq;
        sq = 32'(level) * 32'(level);
        if (32'(level) == max_level(bits)) begin
            return max_level(bits);
        end
        return sq >> bits;
    endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Stream signals between the LED register block (master) and the fader (slave).
interface led_pwm_fader_if #(
    parameter int unsigned NUM_LEDS = 10
);
    logic [NUM_LEDS-1:0] leds_in;
    logic                bypass;
    logic [NUM_LEDS-1:0] led_out;
    logic                busy;

    modport master (
        output leds_in,
        output bypass,
        input  led_out,
        input  busy
    );

    modport slave (
        input  leds_in,
        input  bypass,
        output led_out,
        output busy
    );
endinterface

// File: rtl/led_pwm_fader_channel.sv
// One fader channel: ramp FSM, brightness level and registered PWM compare.
// Duty curve is square-law when LED_FADE_GAMMA_EN is defined, linear otherwise.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tgt,
    input  logic                tick,
    input  logic                bypass,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                moving
);

    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_W  = (PWM_BITS+1)'(max_level(PWM_BITS));
    localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP);

    fade_state_e         state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS:0]   sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
            level_q <= '0;
            led     <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            led     <= (duty > pwm_cnt);
        end
    end

    // A direction change always consumes its cycle; a coincident tick is not applied.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        sum     = {1'b0, level_q} + STEP_W;
        if (bypass) begin
            level_d = tgt ? '1 : '0;
            state_d = tgt ? ON : OFF;
        end else begin
            unique case (state_q)
                OFF: begin
                    if (tgt) state_d = RISING;
                end
                RISING: begin
                    if (!tgt) begin
                        state_d = FALLING;
                    end else if (tick) begin
                        if (sum >= MAX_W) begin
                            level_d = '1;
                            state_d = ON;
                        end else begin
                            level_d = sum[PWM_BITS-1:0];
                        end
                    end
                end
                ON: begin
                    if (!tgt) state_d = FALLING;
                end
                FALLING: begin
                    if (tgt) begin
                        state_d = RISING;
                    end else if (tick) begin
                        if ({1'b0, level_q} <= STEP_W) begin
                            level_d = '0;
                            state_d = OFF;
                        end else begin
                            level_d = level_q - STEP_N;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
`ifdef LED_FADE_GAMMA_EN
        duty = PWM_BITS'(gamma(16'(level_q), PWM_BITS));
`else
        duty = level_q;
`endif
    end

    assign moving = (state_q == RISING) || (state_q == FALLING);

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: target register, fade prescaler, PWM counter, busy flag.
// Define LED_FADE_GAMMA_EN for a square-law duty curve in every channel.
module led_pwm_fader
    import led_fade_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 10,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned FADE_DIV = 50000,
    parameter int unsigned STEP     = 8
) (
    input  logic            clk,
    input  logic            reset,
    led_pwm_fader_if.slave  bus
);

    localparam int unsigned MAXV  = max_level(PWM_BITS);
    localparam int unsigned PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [NUM_LEDS-1:0] tgt;
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] moving;
    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                busy_q;

    assign tick = (presc == PRE_W'(FADE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt     <= '0;
            presc   <= '0;
            pwm_cnt <= '0;
            busy_q  <= 1'b0;
        end else begin
            tgt     <= bus.leds_in;
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= (pwm_cnt == PWM_BITS'(MAXV - 1)) ? '0 : pwm_cnt + 1'b1;
            busy_q  <= |moving;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tgt     (tgt[i]),
            .tick    (tick),
            .bypass  (bus.bypass),
            .pwm_cnt (pwm_cnt),
            .led     (led_q[i]),
            .moving  (moving[i])
        );
    end

    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed table, corner sequences and a
// target-seeking reference model run against randomized inputs.
module tb_led_pwm_fader;

    localparam int unsigned NL   = 10;
    localparam int unsigned FD   = 4;
    localparam int unsigned ST   = 32;
    localparam int unsigned MAXV = 255;
    localparam int unsigned FD2  = 2000;
    localparam int unsigned ST2  = 128;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    led_pwm_fader_if #(.NUM_LEDS(NL)) bus ();
    led_pwm_fader_if #(.NUM_LEDS(NL)) bus2 ();

    led_pwm_fader #(.NUM_LEDS(NL), .PWM_BITS(8), .FADE_DIV(FD), .STEP(ST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    led_pwm_fader #(.NUM_LEDS(NL), .PWM_BITS(8), .FADE_DIV(FD2), .STEP(ST2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned duty_of(input int unsigned l);
`ifdef LED_FADE_GAMMA_EN
        return (l == MAXV) ? MAXV : (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    // Reference: each level seeks its target on ticks, except in a cycle where the
    // target just changed; bypass snaps level to target.
    int unsigned     m_lvl [NL];
    logic [NL-1:0]   m_tq, m_tp, m_mov;
    int unsigned     m_n, m_m;
    logic [NL-1:0]   e_led;
    logic            e_busy;

    initial begin
        bit          tk;
        int unsigned pwm, goal;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < NL; i++) m_lvl[i] = 0;
                m_tq = '0; m_tp = '0; m_mov = '0; m_n = 0; m_m = 0;
                e_led = '0; e_busy = 1'b0;
            end else begin
                tk     = ((m_n % FD) == FD - 1);
                pwm    = m_m % MAXV;
                e_busy = |m_mov;
                for (int i = 0; i < NL; i++) e_led[i] = (duty_of(m_lvl[i]) > pwm);
                for (int i = 0; i < NL; i++) begin
                    goal = m_tq[i] ? MAXV : 0;
                    if (bus.bypass) begin
                        m_lvl[i] = goal;
                        m_mov[i] = 1'b0;
                    end else if (m_tq[i] != m_tp[i]) begin
                        m_mov[i] = 1'b1;
                    end else if (m_mov[i] && tk) begin
                        if (m_tq[i]) m_lvl[i] = (m_lvl[i] + ST > MAXV) ? MAXV : m_lvl[i] + ST;
                        else         m_lvl[i] = (m_lvl[i] < ST) ? 0 : m_lvl[i] - ST;
                        if (m_lvl[i] == goal) m_mov[i] = 1'b0;
                    end
                end
                m_tp = m_tq;
                m_tq = bus.leds_in;
                m_n++;
                m_m++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mdl_led_out", bus.led_out, e_led);
                check("mdl_busy", bus.busy, e_busy);
                check("mdl_level0", dut.g_ch[0].u_ch.level_q, m_lvl[0]);
            end
        end
    end

    typedef struct {
        logic [NL-1:0] leds;
        logic          byp;
        int unsigned   hold;
        logic [NL-1:0] exp_led;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        bus.leds_in = '0;
        bus.bypass  = 1'b1;
        step(4);
        bus.bypass  = 1'b0;
        step(2);
    endtask

    initial begin
        int unsigned q[$];
        int unsigned exp_q[$];
        int unsigned lv, prev, mx, hi;
        bit          got;

        vecs[0] = '{10'h3FF, 1'b1, 4,  10'h3FF, 1'b0};
        vecs[1] = '{10'h000, 1'b1, 4,  10'h000, 1'b0};
        vecs[2] = '{10'h155, 1'b0, 60, 10'h155, 1'b0};
        vecs[3] = '{10'h2AA, 1'b0, 60, 10'h2AA, 1'b0};
        vecs[4] = '{10'h0F0, 1'b1, 4,  10'h0F0, 1'b0};
        vecs[5] = '{10'h30F, 1'b0, 60, 10'h30F, 1'b0};

        reset        = 1'b1;
        bus.leds_in  = 10'h3FF;
        bus.bypass   = 1'b0;
        bus2.leds_in = '0;
        bus2.bypass  = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset held with all targets high
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_led_out", bus.led_out, 0);
            check("rst_busy", bus.busy, 0);
        end
        reset = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
            @(negedge clk);
            if (bus.busy) got = 1'b1;
        end
        check("rst_busy_rise", got, 1);
        clear_all();

        // Settled-state table
        for (int v = 0; v < 6; v++) begin
            bus.leds_in = vecs[v].leds;
            bus.bypass  = vecs[v].byp;
            step(vecs[v].hold);
            check("tbl_led_out", bus.led_out, vecs[v].exp_led);
            check("tbl_busy", bus.busy, vecs[v].exp_busy);
        end
        bus.bypass = 1'b0;

        // Ramp up channel 0
        clear_all();
        bus.leds_in = 10'h001;
        q = {};
        prev = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            lv = dut.g_ch[0].u_ch.level_q;
            if (lv != prev) q.push_back(lv);
            prev = lv;
            if (lv == MAXV) break;
        end
        exp_q = {32, 64, 96, 128, 160, 192, 224, 255};
        check("ramp_steps", q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < q.size(); k++) check("ramp_level", q[k], exp_q[k]);
        check("ramp_busy_at_max", bus.busy, 1);
        step(1);
        check("ramp_busy_drop", bus.busy, 0);
        got = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (bus.led_out !== 10'h001) got = 1'b0;
            step(1);
        end
        check("ramp_led_const", got, 1);

        // Reversal from 96
        clear_all();
        bus.leds_in = 10'h001;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (dut.g_ch[0].u_ch.level_q == 96) got = 1'b1;
        end
        check("rev_reach96", got, 1);
        bus.leds_in = '0;
        q = {};
        prev = 96;
        mx = 96;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            lv = dut.g_ch[0].u_ch.level_q;
            if (lv > mx) mx = lv;
            if (lv != prev) q.push_back(lv);
            prev = lv;
            if (lv == 0) break;
        end
        exp_q = {64, 32, 0};
        check("rev_max", mx, 96);
        check("rev_steps", q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < q.size(); k++) check("rev_level", q[k], exp_q[k]);
        step(1);
        check("rev_busy_drop", bus.busy, 0);

        // Bypass
        bus.bypass  = 1'b1;
        bus.leds_in = 10'h2AA;
        step(1);
        check("byp_busy1", bus.busy, 0);
        step(1);
        check("byp_level1", dut.g_ch[1].u_ch.level_q, 255);
        check("byp_level0", dut.g_ch[0].u_ch.level_q, 0);
        check("byp_busy2", bus.busy, 0);
        step(1);
        check("byp_led_out", bus.led_out, 10'h2AA);
        bus.leds_in = '0;
        step(2);
        check("byp_clear_level1", dut.g_ch[1].u_ch.level_q, 0);
        check("byp_busy3", bus.busy, 0);
        bus.bypass = 1'b0;
        step(2);

        // Reset mid-ramp on channel 3
        bus.leds_in = 10'h008;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (dut.g_ch[3].u_ch.level_q == 160) got = 1'b1;
        end
        check("mid_reach160", got, 1);
        reset = 1'b1;
        step(1);
        check("mid_level3", dut.g_ch[3].u_ch.level_q, 0);
        check("mid_led3", bus.led_out[3], 0);
        check("mid_busy", bus.busy, 0);
        reset = 1'b0;
        bus.leds_in = '0;
        step(2);

        // Randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) bus.leds_in = NL'($urandom);
            bus.bypass = ($urandom_range(31) == 0);
            reset      = ($urandom_range(399) == 0);
            step(1);
        end
        reset      = 1'b0;
        bus.bypass = 1'b0;
        step(2);

        // Duty at a frozen level of 128 on the slow instance
        bus2.leds_in = 10'h001;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            if (dut2.g_ch[0].u_ch.level_q == 128) got = 1'b1;
        end
        check("duty_reach128", got, 1);
        step(2);
        hi = 0;
        for (int k = 0; k < 255; k++) begin
            if (bus2.led_out[0]) hi++;
            step(1);
        end
`ifdef LED_FADE_GAMMA_EN
        check("duty_high_cycles", hi, 64);
`else
        check("duty_high_cycles", hi, 128);
`endif
        check("duty_level_held", dut2.g_ch[0].u_ch.level_q, 128);
        check("duty_others_off", bus2.led_out[NL-1:1], 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
